// File: rtl/int_controller_pkg.sv
// Shared definitions for the interrupt controller.
//   - ic_state_e : 2-bit encodings of the request/service handshake states
//   - IC_NSRC_DEFAULT : default number of interrupt sources
package int_controller_pkg;

  localparam int unsigned IC_NSRC_DEFAULT = 4;

  typedef enum logic [1:0] {
    IC_IDLE    = 2'd0,
    IC_REQ     = 2'd1,
    IC_SERVICE = 2'd2
  } ic_state_e;

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-wins priority encoder. Reusable by any arbiter that
// needs a fixed-priority pick.
//   req_i   : request vector, bit 0 is highest priority
//   idx_o   : index of the lowest set bit (0 when none set)
//   valid_o : at least one request is set
module prio_enc
  import int_controller_pkg::*;
#(
  parameter int unsigned NSRC  = IC_NSRC_DEFAULT,
  parameter int unsigned VEC_W = 2
) (
  input  logic [NSRC-1:0]  req_i,
  output logic [VEC_W-1:0] idx_o,
  output logic             valid_o
);

  // Scan from the top down so the last hit, the lowest index, wins.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = VEC_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_controller.sv
// Interrupt controller between peripheral interrupt sources and the CPU.
// Rising edges of each source latch into a pending register, a CPU-written
// mask filters them, a fixed-priority pick selects one source, and a
// request / acknowledge / end-of-interrupt handshake presents its vector.
// One interrupt in service at a time, no nesting.
//   clk, clr       : clock, asynchronous active-high reset
//   global_int_en  : CPU global interrupt enable
//   irq_src        : raw source levels (already synchronous to clk)
//   mask_we/wdata  : mask write strobe and data (1 = masked)
//   mask_q         : current mask
//   pending_q      : current pending bits
//   cpu_irq        : request to the CPU (state REQ)
//   cpu_ack        : CPU accepts the request
//   cpu_eoi        : CPU finished the handler
//   int_vec        : index of the requested / in-service source
//   int_active     : an interrupt is in service (state SERVICE)
module int_controller
  import int_controller_pkg::*;
#(
  parameter int unsigned NSRC  = IC_NSRC_DEFAULT,
  // Must equal clog2(NSRC), minimum 1.
  parameter int unsigned VEC_W = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             global_int_en,
  input  logic [NSRC-1:0]  irq_src,
  input  logic             mask_we,
  input  logic [NSRC-1:0]  mask_wdata,
  output logic [NSRC-1:0]  mask_q,
  output logic [NSRC-1:0]  pending_q,
  output logic             cpu_irq,
  input  logic             cpu_ack,
  input  logic             cpu_eoi,
  output logic [VEC_W-1:0] int_vec,
  output logic             int_active
);

  ic_state_e        state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [NSRC-1:0]  prev_q, prev_d;
  logic [NSRC-1:0]  pending_d;
  logic [NSRC-1:0]  mask_d;

  logic [NSRC-1:0]  irq_rise;
  logic [NSRC-1:0]  ack_clr;
  logic [NSRC-1:0]  eligible;
  logic [VEC_W-1:0] win_idx;
  logic             win_valid;

  // ---------------------------------------------------------------------
  // Edge detect, pending, mask
  // ---------------------------------------------------------------------
  always_comb begin
    irq_rise = irq_src & ~prev_q;
    ack_clr  = '0;
    if ((state_q == IC_REQ) && cpu_ack) begin
      ack_clr = NSRC'(1) << vec_q;
    end
    // Set is applied after clear so a same-cycle re-edge is not lost.
    pending_d = (pending_q & ~ack_clr) | irq_rise;
    mask_d    = mask_we ? mask_wdata : mask_q;
    prev_d    = irq_src;
    eligible  = pending_q & ~mask_q;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      prev_q    <= '0;
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      prev_q    <= prev_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  prio_enc #(
    .NSRC  (NSRC),
    .VEC_W (VEC_W)
  ) u_prio_enc (
    .req_i   (eligible),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  // ---------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IC_IDLE;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    case (state_q)
      IC_IDLE: begin
        if (global_int_en && win_valid) begin
          state_d = IC_REQ;
          vec_d   = win_idx;
        end
      end
      IC_REQ: begin
        // Vector stays frozen; ack beats abort when both occur.
        if (cpu_ack) begin
          state_d = IC_SERVICE;
        end else if (!global_int_en || !eligible[vec_q]) begin
          state_d = IC_IDLE;
        end
      end
      IC_SERVICE: begin
        if (cpu_eoi) begin
          state_d = IC_IDLE;
        end
      end
      default: state_d = IC_IDLE;
    endcase
  end

  // Outputs decode only from registers.
  always_comb begin
    cpu_irq    = (state_q == IC_REQ);
    int_active = (state_q == IC_SERVICE);
    int_vec    = vec_q;
  end

endmodule

// File: tb/tb_int_controller.sv
module tb_int_controller;

  localparam int unsigned NSRC  = 4;
  localparam int unsigned VEC_W = 2;

  logic             clk = 1'b0;
  logic             clr = 1'b0;
  logic             global_int_en = 1'b0;
  logic [NSRC-1:0]  irq_src = '0;
  logic             mask_we = 1'b0;
  logic [NSRC-1:0]  mask_wdata = '0;
  logic [NSRC-1:0]  mask_q;
  logic [NSRC-1:0]  pending_q;
  logic             cpu_irq;
  logic             cpu_ack = 1'b0;
  logic             cpu_eoi = 1'b0;
  logic [VEC_W-1:0] int_vec;
  logic             int_active;

  int_controller #(
    .NSRC  (NSRC),
    .VEC_W (VEC_W)
  ) dut (
    .clk           (clk),
    .clr           (clr),
    .global_int_en (global_int_en),
    .irq_src       (irq_src),
    .mask_we       (mask_we),
    .mask_wdata    (mask_wdata),
    .mask_q        (mask_q),
    .pending_q     (pending_q),
    .cpu_irq       (cpu_irq),
    .cpu_ack       (cpu_ack),
    .cpu_eoi       (cpu_eoi),
    .int_vec       (int_vec),
    .int_active    (int_active)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: the controller's behaviour as a set of plain flags
  // (requesting / busy) plus bit vectors, advanced once per clock.
  // ---------------------------------------------------------------------
  typedef struct packed {
    logic            irq;
    logic            act;
    logic [1:0]      vec;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] mask;
  } exp_t;

  exp_t            sb_q[$];
  logic [NSRC-1:0] m_prev, m_pend, m_mask;
  logic            m_req, m_busy;
  logic [1:0]      m_vec;

  function automatic logic [1:0] lowest_set(input logic [NSRC-1:0] v);
    for (int i = 0; i < int'(NSRC); i++) begin
      if (v[i]) return 2'(i);
    end
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_pend = '0; m_mask = '0;
    m_req = 1'b0; m_busy = 1'b0; m_vec = '0;
    sb_q.delete();
  endtask

  task automatic model_step(input logic gie, input logic [NSRC-1:0] src, input logic mwe,
                            input logic [NSRC-1:0] mw, input logic ack, input logic eoi);
    logic [NSRC-1:0] rise, elig;
    exp_t e;
    rise = src & ~m_prev;
    elig = m_pend & ~m_mask;
    if (m_req && ack) m_pend[m_vec] = 1'b0;
    m_pend = m_pend | rise;
    if (m_req) begin
      if (ack) begin
        m_req = 1'b0; m_busy = 1'b1;
      end else if (!gie || !elig[m_vec]) begin
        m_req = 1'b0;
      end
    end else if (m_busy) begin
      if (eoi) m_busy = 1'b0;
    end else if (gie && elig != '0) begin
      m_req = 1'b1;
      m_vec = lowest_set(elig);
    end
    if (mwe) m_mask = mw;
    m_prev = src;
    e.irq = m_req; e.act = m_busy; e.vec = m_vec; e.pend = m_pend; e.mask = m_mask;
    sb_q.push_back(e);
  endtask

  // Drive one clock of stimulus; returns 2 time units after the edge.
  task automatic step(input logic gie, input logic [NSRC-1:0] src, input logic mwe,
                      input logic [NSRC-1:0] mw, input logic ack, input logic eoi);
    @(negedge clk);
    global_int_en = gie; irq_src = src; mask_we = mwe; mask_wdata = mw;
    cpu_ack = ack; cpu_eoi = eoi;
    model_step(gie, src, mwe, mw, ack, eoi);
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare DUT outputs with the oldest expected snapshot.
  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (!clr && sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("sb_cpu_irq", cpu_irq, mon_e.irq);
      check("sb_int_active", int_active, mon_e.act);
      check("sb_pending", pending_q, mon_e.pend);
      check("sb_mask", mask_q, mon_e.mask);
      if (mon_e.irq || mon_e.act) check("sb_int_vec", int_vec, mon_e.vec);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  logic [NSRC-1:0] cur_src;

  initial begin
    model_reset();
    #1 clr = 1'b1;
    #1;
    check("reset_irq", cpu_irq, 0);
    check("reset_active", int_active, 0);
    check("reset_pending", pending_q, 0);
    check("reset_mask", mask_q, 0);
    check("reset_vec", int_vec, 0);
    @(posedge clk);
    #2 clr = 1'b0;

    // 1: single source
    step(1, 4'b0010, 0, 0, 0, 0);
    check("t1_irq_early", cpu_irq, 0);
    check("t1_pending", pending_q, 4'b0010);
    step(1, 4'b0000, 0, 0, 0, 0);
    check("t1_irq", cpu_irq, 1);
    check("t1_vec", int_vec, 1);
    step(1, 4'b0000, 0, 0, 1, 0);
    check("t1_ack_pending", pending_q, 0);
    check("t1_ack_active", int_active, 1);
    check("t1_ack_irq", cpu_irq, 0);
    step(1, 4'b0000, 0, 0, 0, 1);
    check("t1_eoi_active", int_active, 0);

    // 2: priority
    step(1, 4'b1001, 0, 0, 0, 0);
    step(1, 4'b0000, 0, 0, 0, 0);
    check("t2_first_vec", int_vec, 0);
    check("t2_first_irq", cpu_irq, 1);
    step(1, 4'b0000, 0, 0, 1, 0);
    step(1, 4'b0000, 0, 0, 0, 1);
    check("t2_gap_irq", cpu_irq, 0);
    step(1, 4'b0000, 0, 0, 0, 0);
    check("t2_second_vec", int_vec, 3);
    check("t2_second_irq", cpu_irq, 1);
    step(1, 4'b0000, 0, 0, 1, 0);
    step(1, 4'b0000, 0, 0, 0, 1);
    check("t2_pending_end", pending_q, 0);

    // 3: mask
    step(1, 4'b0000, 1, 4'b0001, 0, 0);
    step(1, 4'b0001, 0, 0, 0, 0);
    step(1, 4'b0000, 0, 0, 0, 0);
    step(1, 4'b0000, 0, 0, 0, 0);
    check("t3_masked_pending", pending_q, 4'b0001);
    check("t3_masked_irq", cpu_irq, 0);
    step(1, 4'b0000, 1, 4'b0000, 0, 0);
    check("t3_unmask_irq_early", cpu_irq, 0);
    step(1, 4'b0000, 0, 0, 0, 0);
    check("t3_unmask_irq", cpu_irq, 1);
    step(1, 4'b0000, 0, 0, 1, 0);
    step(1, 4'b0000, 0, 0, 0, 1);

    // 4: abort in REQ
    step(1, 4'b0100, 0, 0, 0, 0);
    step(1, 4'b0000, 0, 0, 0, 0);
    check("t4_irq", cpu_irq, 1);
    step(0, 4'b0000, 0, 0, 0, 0);
    check("t4_abort_irq", cpu_irq, 0);
    check("t4_abort_pending", pending_q, 4'b0100);
    step(1, 4'b0000, 0, 0, 0, 0);
    check("t4_rearm_irq", cpu_irq, 1);
    check("t4_rearm_vec", int_vec, 2);
    step(1, 4'b0000, 0, 0, 1, 0);
    step(1, 4'b0000, 0, 0, 0, 1);

    // 5: re-edge in the same cycle as ack
    step(1, 4'b0100, 0, 0, 0, 0);
    step(1, 4'b0000, 0, 0, 0, 0);
    step(1, 4'b0100, 0, 0, 1, 0);
    check("t5_pending_kept", pending_q, 4'b0100);
    check("t5_active", int_active, 1);
    step(1, 4'b0000, 0, 0, 0, 1);
    step(1, 4'b0000, 0, 0, 0, 0);
    check("t5_second_irq", cpu_irq, 1);
    check("t5_second_vec", int_vec, 2);
    step(1, 4'b0000, 0, 0, 1, 0);
    step(1, 4'b0000, 0, 0, 0, 1);

    // 6: reset mid-service
    step(1, 4'b0001, 1, 4'b1000, 0, 0);
    step(1, 4'b0000, 0, 0, 0, 0);
    step(1, 4'b0000, 0, 0, 1, 0);
    check("t6_pre_active", int_active, 1);
    #4 clr = 1'b1;
    irq_src = 4'b0100;
    #1;
    check("t6_async_irq", cpu_irq, 0);
    check("t6_async_active", int_active, 0);
    check("t6_async_pending", pending_q, 0);
    check("t6_async_mask", mask_q, 0);
    check("t6_async_vec", int_vec, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2 clr = 1'b0;
    step(1, 4'b0100, 0, 0, 0, 0);
    check("t6_release_irq_early", cpu_irq, 0);
    step(1, 4'b0100, 0, 0, 0, 0);
    check("t6_release_irq", cpu_irq, 1);
    check("t6_release_vec", int_vec, 2);

    // Random traffic against the model
    cur_src = 4'b0100;
    for (int n = 0; n < 1500; n++) begin
      logic gie, mwe, ack, eoi;
      logic [NSRC-1:0] mw;
      gie = ($urandom_range(0, 9) != 0);
      cur_src = cur_src ^ NSRC'($urandom & $urandom);
      mwe = ($urandom_range(0, 15) == 0);
      mw  = NSRC'($urandom & $urandom);
      ack = ($urandom_range(0, 2) == 0);
      eoi = ($urandom_range(0, 3) == 0);
      step(gie, cur_src, mwe, mw, ack, eoi);
    end

    @(posedge clk);
    #3;
    check("sb_drain", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/int_controller.md
# int_controller

Interrupt controller between the peripheral interrupt sources (timer `irq_pin`, keyboard, UART, …) and the CPU core. It latches rising edges of each source into a pending register and applies a CPU-writable mask. A fixed-priority choice picks one source, and a request/acknowledge/end-of-interrupt handshake presents that source's vector to the CPU. Only one interrupt is in service at a time; there is no nesting.

## Interface
- `NSRC`, 4, number of interrupt sources; index 0 is highest priority.
- `VEC_W`, 2, vector width; must equal clog2(`NSRC`), minimum 1.

- `clk` in 1: system clock; all state updates on the rising edge.
- `clr` in 1: reset, asynchronous, active-high.
- `global_int_en` in 1: CPU global interrupt enable.
- `irq_src` in `NSRC`: raw source levels, already synchronous to `clk`.
- `mask_we` in 1: mask write strobe.
- `mask_wdata` in `NSRC`: new mask value; 1 masks that source.
- `mask_q` out `NSRC`: current mask.
- `pending_q` out `NSRC`: current pending bits.
- `cpu_irq` out 1: interrupt request to the CPU.
- `cpu_ack` in 1: CPU accepts the request.
- `cpu_eoi` in 1: CPU has finished the handler.
- `int_vec` out `VEC_W`: index of the requested or in-service source.
- `int_active` out 1: an interrupt is in service.

## Operation
- **Edge detect.** `prev` is a per-source register of `irq_src`. A rising edge is `irq_src & ~prev`. `prev` resets to 0, so a source that is high when `clr` releases counts as an edge in the first cycle.
- **Pending register.**
  - A bit sets on its source's edge.
  - A bit clears when that source is acknowledged.
  - If an edge and a clear hit the same bit in the same cycle, set wins.
  - Masked sources still latch pending bits.
- **Mask.** `mask_we` loads `mask_wdata` at the next edge.
- **Eligibility.** `eligible = pending_q & ~mask_q`. The winner is the lowest set index of `eligible`.
- **FSM states:** IDLE, REQ, SERVICE.
  - **IDLE.** If `global_int_en` is set and `|eligible`: capture the winner into `int_vec` and go to REQ.
  - **REQ.**
    - `int_vec` stays frozen; a newly arriving higher-priority source does not replace it.
    - On `cpu_ack`: clear `pending_q[int_vec]` and go to SERVICE.
    - Otherwise, if `global_int_en` is low or `eligible[int_vec]` is 0 (for example it was masked meanwhile): return to IDLE. The pending bit is kept.
  - **SERVICE.** On `cpu_eoi`, go to IDLE.
- **Ignored inputs.** `cpu_ack` outside REQ and `cpu_eoi` outside SERVICE are ignored. If `cpu_ack` and the abort condition occur together in REQ, `cpu_ack` wins.
- **Decoded outputs.** `cpu_irq` = (state==REQ) and `int_active` = (state==SERVICE). Both decode directly from the state register, with no combinational path from inputs.
- **Reset.** On `clr`:
  - state goes to IDLE;
  - `cpu_irq`, `int_active`, `int_vec`, `pending_q` and `prev` all go to 0;
  - `mask_q` goes to 0, so all sources are unmasked by default.
  
  Reset in the middle of a REQ or SERVICE sequence drops the sequence immediately, with no completion.

## Timing
- **Edge to request.** If a source's edge is sampled at clock t, its `pending_q` bit is 1 after t. The FSM enters REQ at t+1 and `cpu_irq` is high from t+1. Minimum latency from edge to `cpu_irq` is 2 clocks.
- **Acknowledge.** `cpu_ack` sampled at clock a: after a, `cpu_irq` = 0, `int_active` = 1 and the pending bit is cleared.
- **End of interrupt.** `cpu_eoi` sampled at clock e: `int_active` = 0 after e. The next REQ comes no earlier than the clock after e, so `cpu_irq` is low for at least 1 cycle between services.
- **Mask write.** Takes effect for eligibility in the cycle after `mask_we`.
- **Vector stability.** `int_vec` is stable from REQ entry through the end of SERVICE.

## Structure
- **Shared define file:** the IC_IDLE, IC_REQ and IC_SERVICE state encodings (2 bits) and the default `NSRC`.
- **Sub-module `prio_enc`:** parameterised `NSRC`-to-`VEC_W` lowest-index priority encoder with a `valid` output. It is reused by a future DMA arbiter.

## Test plan
1. **Single source.** Pulse `irq_src`=4'b0010 for 1 cycle, `global_int_en`=1 → `cpu_irq` rises 2 cycles later with `int_vec`=1. `cpu_ack` → `pending_q`=0 and `int_active`=1. `cpu_eoi` → back to idle.
2. **Priority.** Edges on sources 3 and 0 in the same cycle → first service has `int_vec`=0. After `cpu_eoi`, a second REQ has `int_vec`=3. `pending_q` ends at 0.
3. **Mask.** `mask_wdata`=4'b0001, then an edge on source 0 → `pending_q`=4'b0001 and `cpu_irq` stays 0. Unmask → `cpu_irq` 2 cycles after the write.
4. **Abort in REQ.** While `cpu_irq`=1, drop `global_int_en` → `cpu_irq`=0 next cycle and the pending bit is retained. Re-enable → the request is re-raised.
5. **Re-edge during clear.** An edge on source 2 in the same cycle as `cpu_ack` for source 2 → `pending_q[2]` stays 1. A second service of source 2 follows the `cpu_eoi`.
6. **Reset mid-service.** Assert `clr` while in SERVICE → all outputs 0 asynchronously. A source held high through the release of `clr` produces `cpu_irq` 2 cycles after the release.
